// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues stall-tolerant reads and queues {pc, word}
// pairs in order for decode. Redirects from execute honour an optional branch delay slot.
//   state   | meaning
//   S_RUN   | sequential fetch at fetch_pc
//   S_DELAY | fetching the delay-slot word at fetch_pc, then jump to saved_target
//   S_DRAIN | stalled request for a discarded address; drop its data, then jump to saved_target
module fetch_stage #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          FIFO_DEPTH   = 2,
    parameter int          DELAY_SLOT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] instr_read_addr,
    output logic              instr_read,
    input  logic              instr_waitrequest,
    input  logic [31:0]       instr_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [5:0]        instruction_opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        func_code,
    output logic [15:0]       alu_immediate,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {S_RUN, S_DELAY, S_DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic [ADDR_W-1:0] saved_target, saved_n;
    logic              stalled_q;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [31:0]       fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];

    logic              accept, stalled_now, pop, redirect;
    logic              push, trim, flush;
    logic [ADDR_W-1:0] target_al;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RUN;
            fetch_pc     <= RST_PC;
            saved_target <= RST_PC;
            stalled_q    <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            saved_target <= saved_n;
            stalled_q    <= stalled_now;
            rd_ptr       <= rd_ptr_n;
            wr_ptr       <= wr_ptr_n;
            count        <= count_n;
            if (push) begin
                fifo_instr[wr_ptr] <= instr_read_data;
                fifo_pc[wr_ptr]    <= fetch_pc;
            end
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        saved_n    = saved_target;
        push       = 1'b0;
        trim       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            saved_n = target_al;
            if (DELAY_SLOT == 0) begin
                flush = 1'b1;
                if (stalled_now) begin
                    state_n = S_DRAIN;
                end else begin
                    fetch_pc_n = target_al;
                    state_n    = S_RUN;
                end
            end else if (state == S_RUN && count == CNT_ONE) begin
                // FIFO empties on this pop, so the word in flight is the delay slot.
                if (accept) begin
                    push       = 1'b1;
                    fetch_pc_n = target_al;
                end else begin
                    state_n = S_DELAY;
                end
            end else begin
                trim = 1'b1;
                if (stalled_now) begin
                    state_n = S_DRAIN;
                end else begin
                    fetch_pc_n = target_al;
                    state_n    = S_RUN;
                end
            end
        end else if (accept) begin
            case (state)
                S_RUN: begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + PC_STEP;
                end
                S_DELAY: begin
                    push       = 1'b1;
                    fetch_pc_n = saved_target;
                    state_n    = S_RUN;
                end
                default: begin
                    fetch_pc_n = saved_target;
                    state_n    = S_RUN;
                end
            endcase
        end

        rd_ptr_n = pop  ? rd_ptr + PTR_ONE : rd_ptr;
        wr_ptr_n = push ? wr_ptr + PTR_ONE : wr_ptr;
        count_n  = count + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            rd_ptr_n = wr_ptr;
            count_n  = '0;
        end else if (trim) begin
            if (count > CNT_ONE) begin
                wr_ptr_n = rd_ptr_n + PTR_ONE;
                count_n  = CNT_ONE;
            end else begin
                wr_ptr_n = rd_ptr_n;
                count_n  = '0;
            end
        end
    end

    always_comb begin
        instr_read         = ~reset & (stalled_q | (count < DEPTH_C));
        instr_read_addr    = fetch_pc;
        accept             = instr_read & ~instr_waitrequest;
        stalled_now        = instr_read & instr_waitrequest;
        out_valid          = (count != '0);
        pop                = out_valid & out_ready;
        redirect           = redirect_valid & pop;
        target_al          = redirect_target & ALIGN_MASK;
        out_instr          = fifo_instr[rd_ptr];
        out_pc             = fifo_pc[rd_ptr];
        instruction_opcode = out_instr[31:26];
        rs                 = out_instr[25:21];
        rt                 = out_instr[20:16];
        rd                 = out_instr[15:11];
        shamt              = out_instr[10:6];
        func_code          = out_instr[5:0];
        alu_immediate      = out_instr[15:0];
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one instance with a delay slot, one with full flush.
module tb_fetch_stage;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] addr1, data1, instr1, pc1, target1;
    logic        read1, wait1, valid1, ready1, rv1, ovr1;
    logic [5:0]  op1, fn1;
    logic [4:0]  rs1, rt1, rd1, sh1;
    logic [15:0] imm1;

    logic [31:0] addr0, data0, instr0, pc0, target0;
    logic        read0, wait0, valid0, ready0, rv0;
    logic [5:0]  op0, fn0;
    logic [4:0]  rs0, rt0, rd0, sh0;
    logic [15:0] imm0;

    assign data1 = ovr1 ? 32'h012A4020 : (addr1 ^ 32'h5A5A0000);
    assign data0 = addr0 ^ 32'h5A5A0000;

    fetch_stage #(.ADDR_W(32), .RESET_VECTOR(RV), .FIFO_DEPTH(2), .DELAY_SLOT(1)) dut1 (
        .clk(clk), .reset(reset),
        .instr_read_addr(addr1), .instr_read(read1), .instr_waitrequest(wait1),
        .instr_read_data(data1), .out_valid(valid1), .out_ready(ready1),
        .out_instr(instr1), .out_pc(pc1), .instruction_opcode(op1),
        .rs(rs1), .rt(rt1), .rd(rd1), .shamt(sh1), .func_code(fn1), .alu_immediate(imm1),
        .redirect_valid(rv1), .redirect_target(target1)
    );

    fetch_stage #(.ADDR_W(32), .RESET_VECTOR(RV), .FIFO_DEPTH(2), .DELAY_SLOT(0)) dut0 (
        .clk(clk), .reset(reset),
        .instr_read_addr(addr0), .instr_read(read0), .instr_waitrequest(wait0),
        .instr_read_data(data0), .out_valid(valid0), .out_ready(ready0),
        .out_instr(instr0), .out_pc(pc0), .instruction_opcode(op0),
        .rs(rs0), .rt(rt0), .rd(rd0), .shamt(sh0), .func_code(fn0), .alu_immediate(imm0),
        .redirect_valid(rv0), .redirect_target(target0)
    );

    logic [63:0] pops1[$];
    logic [63:0] pops0[$];
    logic [31:0] acc1[$];
    logic [31:0] acc0[$];

    always @(posedge clk) begin
        if (!reset) begin
            if (valid1 && ready1) pops1.push_back({pc1, instr1});
            if (read1 && !wait1)  acc1.push_back(addr1);
            if (valid0 && ready0) pops0.push_back({pc0, instr0});
            if (read0 && !wait0)  acc0.push_back(addr0);
            if (rv1 && !(valid1 && ready1)) begin
                errors++;
                $display("FAIL protocol_dut1: redirect_valid=%b without pop (valid=%b ready=%b)", rv1, valid1, ready1);
            end
            if (rv0 && !(valid0 && ready0)) begin
                errors++;
                $display("FAIL protocol_dut0: redirect_valid=%b without pop (valid=%b ready=%b)", rv0, valid0, ready0);
            end
        end
    end

    // Out-of-range reads return an odd address, which no real fetch can produce.
    function automatic logic [31:0] pc_at1(input int i);
        if (i < pops1.size()) return pops1[i][63:32];
        return 32'h0000_0001;
    endfunction

    function automatic logic [31:0] pc_at0(input int i);
        if (i < pops0.size()) return pops0[i][63:32];
        return 32'h0000_0001;
    endfunction

    function automatic logic [31:0] acc_at1(input int i);
        if (i < acc1.size()) return acc1[i];
        return 32'h0000_0001;
    endfunction

    function automatic logic [31:0] acc_at0(input int i);
        if (i < acc0.size()) return acc0[i];
        return 32'h0000_0001;
    endfunction

    task automatic idle_inputs();
        wait1 = 1'b0; ready1 = 1'b0; rv1 = 1'b0; target1 = '0; ovr1 = 1'b0;
        wait0 = 1'b0; ready0 = 1'b0; rv0 = 1'b0; target0 = '0;
    endtask

    // Returns at the falling edge where reset is released (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        pops1.delete(); pops0.delete(); acc1.delete(); acc0.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (read1 !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", read1); end
        checks++;
        if (valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid1); end
        checks++;
        if (addr1 !== RV) begin errors++; $display("FAIL rst_addr: got %h expected %h", addr1, RV); end
        checks++;
        if ({op1, rs1, rt1, rd1, sh1, fn1, imm1} !== 48'h0) begin
            errors++; $display("FAIL rst_fields: got %h expected 0", {op1, rs1, rt1, rd1, sh1, fn1, imm1});
        end
        checks++;
        if (read0 !== 1'b0 || addr0 !== RV) begin
            errors++; $display("FAIL rst_dut0: got read=%b addr=%h expected read=0 addr=%h", read0, addr0, RV);
        end
    endtask

    task automatic test_fetch_seq();
        do_reset();
        ready1 = 1'b1;
        #1;
        checks++;
        if (read1 !== 1'b1 || addr1 !== RV) begin
            errors++; $display("FAIL first_req: got read=%b addr=%h expected read=1 addr=%h", read1, addr1, RV);
        end
        checks++;
        if (valid1 !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0", valid1); end
        repeat (5) @(negedge clk);
        checks++;
        if (pc_at1(0) !== RV) begin errors++; $display("FAIL seq_pc0: got %h expected %h", pc_at1(0), RV); end
        checks++;
        if (pc_at1(1) !== RV + 32'd4) begin errors++; $display("FAIL seq_pc1: got %h expected %h", pc_at1(1), RV + 32'd4); end
        checks++;
        if (pc_at1(2) !== RV + 32'd8) begin errors++; $display("FAIL seq_pc2: got %h expected %h", pc_at1(2), RV + 32'd8); end
        checks++;
        if (pops1.size() < 1 || pops1[0][31:0] !== 32'hE59A0000) begin
            errors++; $display("FAIL seq_word0: got %h expected e59a0000", (pops1.size() > 0) ? pops1[0][31:0] : 32'h0);
        end
    endtask

    task automatic test_fields();
        do_reset();
        ovr1 = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (valid1 !== 1'b1 || pc1 !== RV || instr1 !== 32'h012A4020) begin
            errors++; $display("FAIL fld_head: got valid=%b pc=%h instr=%h expected 1 %h 012a4020", valid1, pc1, instr1, RV);
        end
        checks++;
        if (op1 !== 6'd0 || fn1 !== 6'h20) begin
            errors++; $display("FAIL fld_op_fn: got op=%h fn=%h expected 00 20", op1, fn1);
        end
        checks++;
        if (rs1 !== 5'd9 || rt1 !== 5'd10 || rd1 !== 5'd8 || sh1 !== 5'd0) begin
            errors++; $display("FAIL fld_regs: got rs=%0d rt=%0d rd=%0d sh=%0d expected 9 10 8 0", rs1, rt1, rd1, sh1);
        end
        checks++;
        if (imm1 !== 16'h4020) begin errors++; $display("FAIL fld_imm: got %h expected 4020", imm1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (acc1.size() != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", acc1.size()); end
        checks++;
        if (read1 !== 1'b0 || valid1 !== 1'b1) begin
            errors++; $display("FAIL bp_full: got read=%b valid=%b expected read=0 valid=1", read1, valid1);
        end
        ready1 = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (pops1.size() != 6) begin errors++; $display("FAIL bp_pop_count: got %0d expected 6", pops1.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_at1(i) !== RV + 32'(4 * i)) begin
                errors++; $display("FAIL bp_order%0d: got %h expected %h", i, pc_at1(i), RV + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready1 = 1'b1;
        @(negedge clk);
        wait1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (read1 !== 1'b1 || addr1 !== RV + 32'd4) begin
                errors++; $display("FAIL stall_hold%0d: got read=%b addr=%h expected 1 %h", i, read1, addr1, RV + 32'd4);
            end
            @(negedge clk);
        end
        wait1 = 1'b0;
        @(negedge clk);
        checks++;
        if (acc1.size() != 2 || acc_at1(1) !== RV + 32'd4) begin
            errors++; $display("FAIL stall_accept: got n=%0d last=%h expected 2 %h", acc1.size(), acc_at1(1), RV + 32'd4);
        end
    endtask

    task automatic test_redirect_keep_head();
        do_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (pc1 !== RV || read1 !== 1'b0) begin
            errors++; $display("FAIL keep_pre: got pc=%h read=%b expected %h 0", pc1, read1, RV);
        end
        ready1 = 1'b1;
        rv1 = 1'b1;
        target1 = 32'hBFC00103;
        @(negedge clk);
        rv1 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pc_at1(1) !== RV + 32'd4) begin errors++; $display("FAIL keep_slot: got %h expected %h", pc_at1(1), RV + 32'd4); end
        checks++;
        if (pc_at1(2) !== 32'hBFC00100) begin errors++; $display("FAIL keep_tgt: got %h expected bfc00100", pc_at1(2)); end
        checks++;
        if (pc_at1(3) !== 32'hBFC00104) begin errors++; $display("FAIL keep_tgt4: got %h expected bfc00104", pc_at1(3)); end
        checks++;
        if (acc_at1(2) !== 32'hBFC00100) begin errors++; $display("FAIL keep_nofetch8: got %h expected bfc00100", acc_at1(2)); end
    endtask

    task automatic test_redirect_delay();
        do_reset();
        ready1 = 1'b1;
        @(negedge clk);
        wait1 = 1'b1;
        rv1 = 1'b1;
        target1 = 32'hBFC00100;
        @(negedge clk);
        rv1 = 1'b0;
        #1;
        checks++;
        if (read1 !== 1'b1 || addr1 !== RV + 32'd4) begin
            errors++; $display("FAIL delay_hold: got read=%b addr=%h expected 1 %h", read1, addr1, RV + 32'd4);
        end
        @(negedge clk);
        wait1 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pc_at1(1) !== RV + 32'd4) begin errors++; $display("FAIL delay_slot: got %h expected %h", pc_at1(1), RV + 32'd4); end
        checks++;
        if (pc_at1(2) !== 32'hBFC00100 || pc_at1(3) !== 32'hBFC00104) begin
            errors++; $display("FAIL delay_tgt: got %h %h expected bfc00100 bfc00104", pc_at1(2), pc_at1(3));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ready1 = 1'b1;
        @(negedge clk);
        rv1 = 1'b1;
        target1 = 32'hFFFFFFF8;
        @(negedge clk);
        rv1 = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (pc_at1(1) !== RV + 32'd4) begin errors++; $display("FAIL wrap_slot: got %h expected %h", pc_at1(1), RV + 32'd4); end
        checks++;
        if (pc_at1(2) !== 32'hFFFFFFF8 || pc_at1(3) !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_top: got %h %h expected fffffff8 fffffffc", pc_at1(2), pc_at1(3));
        end
        checks++;
        if (pc_at1(4) !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 00000000", pc_at1(4)); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        @(negedge clk);
        wait0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b1;
        rv0 = 1'b1;
        target0 = 32'hBFC00100;
        @(negedge clk);
        rv0 = 1'b0;
        #1;
        checks++;
        if (read0 !== 1'b1 || addr0 !== RV + 32'd4 || valid0 !== 1'b0) begin
            errors++; $display("FAIL drain_hold: got read=%b addr=%h valid=%b expected 1 %h 0", read0, addr0, valid0, RV + 32'd4);
        end
        @(negedge clk);
        wait0 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc_at0(1) !== RV + 32'd4) begin errors++; $display("FAIL drain_acc: got %h expected %h", acc_at0(1), RV + 32'd4); end
        checks++;
        if (pc_at0(0) !== RV || pc_at0(1) !== 32'hBFC00100 || pc_at0(2) !== 32'hBFC00104) begin
            errors++; $display("FAIL drain_seq: got %h %h %h expected %h bfc00100 bfc00104", pc_at0(0), pc_at0(1), pc_at0(2), RV);
        end
        checks++;
        if (pops0.size() != 3) begin errors++; $display("FAIL drain_count: got %0d expected 3", pops0.size()); end
        for (int i = 0; i < pops0.size(); i++) begin
            checks++;
            if (pops0[i][63:32] === RV + 32'd4) begin
                errors++; $display("FAIL drain_leak: got %h at pop %0d expected never delivered", pops0[i][63:32], i);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk);
        wait1 = 1'b1;
        #2;
        checks++;
        if (read1 !== 1'b1 || valid1 !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got read=%b valid=%b expected 1 1", read1, valid1);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (read1 !== 1'b0 || valid1 !== 1'b0 || addr1 !== RV) begin
            errors++; $display("FAIL mid_async: got read=%b valid=%b addr=%h expected 0 0 %h", read1, valid1, addr1, RV);
        end
        @(negedge clk);
        @(negedge clk);
        pops1.delete(); acc1.delete();
        reset = 1'b0;
        wait1 = 1'b0;
        ready1 = 1'b1;
        #1;
        checks++;
        if (read1 !== 1'b1 || addr1 !== RV) begin
            errors++; $display("FAIL mid_restart: got read=%b addr=%h expected 1 %h", read1, addr1, RV);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pc_at1(0) !== RV || pc_at1(1) !== RV + 32'd4) begin
            errors++; $display("FAIL mid_seq: got %h %h expected %h %h", pc_at1(0), pc_at1(1), RV, RV + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_fields();
        test_backpressure();
        test_stall();
        test_redirect_keep_head();
        test_redirect_delay();
        test_wrap();
        test_redirect_drain();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
